// File: rtl/ram_arb.sv
// Two-master SRAM arbiter: video word reads have priority, a streak limit bounds CPU starvation.
// An access in progress (including the 2-cycle memwait word access) is never preempted.
module ram_arb #(
  parameter int VID_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] cpu_adr,
  input  logic        cpu_en,
  input  logic        cpu_ben,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_wait,
  input  logic        vid_req,
  input  logic [17:0] vid_adr,
  output logic        vid_ack,
  output logic [31:0] vid_data,
  output logic [19:0] ram_adr,
  output logic        ram_en,
  output logic        ram_ben,
  output logic        ram_wr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_wait
);

  typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_V} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(VID_MAX);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        vid_ack_q, vid_ack_d;
  logic [31:0] vid_data_q, vid_data_d;

  logic own_c, own_v, vreq, streak_full, done_c, done_v;

  // Owner select; the request seen in the ack cycle is the one just served, so it is masked.
  always_comb begin
    own_c       = 1'b0;
    own_v       = 1'b0;
    vreq        = vid_req & ~vid_ack_q;
    streak_full = (streak_q == STREAK_MAX);
    case (state_q)
      BUSY_C: own_c = 1'b1;
      BUSY_V: own_v = 1'b1;
      default: begin
        if (vreq && !(cpu_en && streak_full)) begin
          own_v = 1'b1;
        end else if (cpu_en) begin
          own_c = 1'b1;
        end else if (vreq) begin
          own_v = 1'b1;
        end
      end
    endcase
  end

  assign done_c = own_c & ~ram_wait;
  assign done_v = own_v & ~ram_wait;

  assign ram_en   = rst_n & (own_c | own_v);
  assign ram_wr   = rst_n & own_c & cpu_wr;
  assign ram_adr  = own_v ? {vid_adr, 2'b00} : cpu_adr;
  assign ram_ben  = own_v ? 1'b0 : cpu_ben;
  assign ram_din  = own_v ? 32'd0 : cpu_din;
  assign cpu_dout = ram_dout;
  assign cpu_wait = rst_n & cpu_en & ~done_c;
  assign vid_ack  = vid_ack_q;
  assign vid_data = vid_data_q;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    vid_ack_d  = done_v;
    vid_data_d = done_v ? ram_dout : vid_data_q;

    case (state_q)
      IDLE: begin
        if (ram_wait) begin
          if (own_v) begin
            state_d = BUSY_V;
          end else if (own_c) begin
            state_d = BUSY_C;
          end
        end
      end
      default: begin
        if (!ram_wait) begin
          state_d = IDLE;
        end
      end
    endcase

    // Streak counts video wins only while the CPU is actually waiting.
    if (done_v) begin
      if (cpu_en) begin
        streak_d = streak_full ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end else if (done_c) begin
      streak_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      vid_ack_q  <= 1'b0;
      vid_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      vid_ack_q  <= vid_ack_d;
      vid_data_q <= vid_data_d;
    end
  end

endmodule
